riscv_fetch_unit: RTL and testbench

Parametrised instruction fetch unit for the next-generation (pipelined) RV32I core. It replaces the single-cycle PC register and combinational instruction-memory path with a decoupled front end. It issues pipelined requests over a req/gnt/rvalid memory interface, buffers returned instructions with their PCs in a prefetch FIFO, and supports redirect (branch/jump) with flush and discard of in-flight responses. It sits between instruction memory and the decode stage.

---
 rtl/riscv_fetch_unit.sv | 120 ++++++++++++
 tb/tb_riscv_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
//   Decoupled instruction fetch front end for the pipelined RV32I core.
//   It issues pipelined word fetches over a req/gnt/rvalid memory port and
//   buffers the returned instructions, each with its PC, in a prefetch FIFO.
//   A redirect flushes the FIFO, restarts fetch at the new PC, and marks the
//   responses still in flight so that they are dropped when they return.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   instr_mem_req_o/addr_o   fetch request and word-aligned address
//   instr_mem_gnt_i          request accepted this cycle
//   instr_mem_rvalid_i       in-order response valid
//   instr_mem_rd_data_i      response instruction word
//   redirect_i/redirect_pc_i flush and restart fetch at a new PC
//   instr_valid_o/ready_i    decode handshake on the FIFO head
//   instr_o/instr_pc_o       head instruction and its PC (zero while empty)
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_mem_req_o,
  output logic [31:0] instr_mem_addr_o,
  input  logic        instr_mem_gnt_i,
  input  logic        instr_mem_rvalid_i,
  input  logic [31:0] instr_mem_rd_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]   fetch_addr, resp_pc;
  logic [OW-1:0] outstanding, discard, outstanding_nxt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  fetch_entry_t  fifo_q [FIFO_DEPTH];

  logic credit_ok, accept, rsp_ok, push, pop;
  logic [31:0] redirect_pc_aligned;

  // Byte offset of a redirect target is ignored; fetch is word aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};

  // Only request when every in-flight response that will actually be kept
  // has a guaranteed FIFO slot; responses marked for discard need no slot.
  // Without a grant this sum can only fall, so a pending request stays up.
  always_comb begin
    credit_ok = (32'(fifo_count) + 32'(outstanding) - 32'(discard)) < 32'(FIFO_DEPTH);
  end

  assign instr_mem_req_o  = reset_n && !redirect_i &&
                            (outstanding < OW'(MAX_OUTSTANDING)) && credit_ok;
  assign instr_mem_addr_o = fetch_addr;

  assign accept = instr_mem_req_o && instr_mem_gnt_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok = instr_mem_rvalid_i && (outstanding != '0);
  assign push   = rsp_ok && !redirect_i && (discard == '0);
  assign instr_valid_o = (fifo_count != '0);
  assign pop    = instr_valid_o && instr_ready_i && !redirect_i;

  assign outstanding_nxt = outstanding + OW'(accept) - OW'(rsp_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr  <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        fetch_addr <= redirect_pc_aligned;
        resp_pc    <= redirect_pc_aligned;
        // Everything still in flight after this cycle belongs to the old path.
        discard    <= outstanding_nxt;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (accept) fetch_addr <= fetch_addr + 32'd4;
        if (rsp_ok && (discard != '0)) discard <= discard - OW'(1);
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: fifo_count qualifies every read.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: resp_pc, instr: instr_mem_rd_data_i};
  end

  assign instr_o    = instr_valid_o ? fifo_q[rd_ptr].instr : '0;
  assign instr_pc_o = instr_valid_o ? fifo_q[rd_ptr].pc    : '0;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
module tb_riscv_fetch_unit;
  localparam logic [31:0] K = 32'hDEAD_0000;  // memory returns addr ^ K

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_mem_req_o;
  logic [31:0] instr_mem_addr_o;
  logic        instr_mem_gnt_i;
  logic        instr_mem_rvalid_i;
  logic [31:0] instr_mem_rd_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  riscv_fetch_unit #(.RESET_PC(32'h1000), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_mem_req_o(instr_mem_req_o), .instr_mem_addr_o(instr_mem_addr_o),
    .instr_mem_gnt_i(instr_mem_gnt_i), .instr_mem_rvalid_i(instr_mem_rvalid_i),
    .instr_mem_rd_data_i(instr_mem_rd_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: granted addresses queue up and return one per cycle,
  // earliest the cycle after the grant, while mem_on is set.
  logic [31:0] q[$];
  logic gnt_en, rdy_en, redir_en, mem_on, force_rv;
  logic [31:0] redir_pc;

  task automatic apply();
    instr_mem_gnt_i = gnt_en;
    instr_ready_i   = rdy_en;
    redirect_i      = redir_en;
    redirect_pc_i   = redir_pc;
    if (force_rv) begin
      instr_mem_rvalid_i  = 1'b1;
      instr_mem_rd_data_i = 32'h1234_5678;
    end else if (mem_on && q.size() > 0) begin
      instr_mem_rvalid_i  = 1'b1;
      instr_mem_rd_data_i = q.pop_front() ^ K;
    end else begin
      instr_mem_rvalid_i  = 1'b0;
      instr_mem_rd_data_i = 32'h0;
    end
    #1;
    if (instr_mem_req_o && instr_mem_gnt_i) q.push_back(instr_mem_addr_o);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    apply();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q.delete();
    instr_mem_gnt_i = 0; instr_ready_i = 0; redirect_i = 0; redirect_pc_i = 0;
    instr_mem_rvalid_i = 0; instr_mem_rd_data_i = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (instr_mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", instr_mem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", instr_valid_o); end
    checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", instr_o); end
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp 0", instr_pc_o); end
    checks++; if (instr_mem_addr_o !== 32'h1000) begin errors++; $display("FAIL rst_addr: got %h exp 1000", instr_mem_addr_o); end
    reset_n = 1'b1;
    apply();
  endtask

  task automatic set_ctl(input logic g, input logic r, input logic m);
    gnt_en = g; rdy_en = r; mem_on = m; redir_en = 0; redir_pc = 0; force_rv = 0;
  endtask

  task automatic test_stream();
    set_ctl(1, 1, 1);
    do_reset();
    checks++; if (instr_mem_req_o !== 1'b1 || instr_mem_addr_o !== 32'h1000) begin errors++; $display("FAIL t1_c0: req %b addr %h exp 1 1000", instr_mem_req_o, instr_mem_addr_o); end
    cyc();
    checks++; if (instr_mem_addr_o !== 32'h1004 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL t1_c1: addr %h valid %b exp 1004 0", instr_mem_addr_o, instr_valid_o); end
    cyc();
    checks++; if (instr_mem_addr_o !== 32'h1008) begin errors++; $display("FAIL t1_c2_addr: got %h exp 1008", instr_mem_addr_o); end
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1000 || instr_o !== (32'h1000 ^ K)) begin errors++; $display("FAIL t1_first: valid %b pc %h instr %h exp 1 1000 %h", instr_valid_o, instr_pc_o, instr_o, 32'h1000 ^ K); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1000 + 32'(4*i)) begin errors++; $display("FAIL t1_sustain%0d: valid %b pc %h exp 1 %h", i, instr_valid_o, instr_pc_o, 32'h1000 + 32'(4*i)); end
    end
    // asynchronous reset mid-stream clears outputs without a clock edge
    reset_n = 1'b0;
    #1;
    checks++; if (instr_valid_o !== 1'b0 || instr_mem_req_o !== 1'b0 || instr_pc_o !== 32'h0) begin errors++; $display("FAIL t1_async_rst: valid %b req %b pc %h exp 0 0 0", instr_valid_o, instr_mem_req_o, instr_pc_o); end
  endtask

  task automatic test_fifo_full();
    set_ctl(1, 0, 1);
    do_reset();
    repeat (4) cyc();
    checks++; if (instr_mem_req_o !== 1'b0) begin errors++; $display("FAIL t2_req_drop: got %b exp 0", instr_mem_req_o); end
    cyc();
    checks++; if (instr_mem_req_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1000) begin errors++; $display("FAIL t2_full: req %b valid %b pc %h exp 0 1 1000", instr_mem_req_o, instr_valid_o, instr_pc_o); end
    cyc();
    rdy_en = 1;
    cyc();
    checks++; if (instr_mem_req_o !== 1'b0) begin errors++; $display("FAIL t2_req_held: got %b exp 0", instr_mem_req_o); end
    rdy_en = 0;
    cyc();
    checks++; if (instr_mem_req_o !== 1'b1 || instr_mem_addr_o !== 32'h1010 || instr_pc_o !== 32'h1004) begin errors++; $display("FAIL t2_reassert: req %b addr %h pc %h exp 1 1010 1004", instr_mem_req_o, instr_mem_addr_o, instr_pc_o); end
    rdy_en = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1000 + 32'(4*i)) begin errors++; $display("FAIL t2_drain%0d: valid %b pc %h exp 1 %h", i, instr_valid_o, instr_pc_o, 32'h1000 + 32'(4*i)); end
    end
  endtask

  task automatic test_gnt_stall();
    set_ctl(0, 1, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_mem_req_o !== 1'b1 || instr_mem_addr_o !== 32'h1000) begin errors++; $display("FAIL t3_stall%0d: req %b addr %h exp 1 1000", i, instr_mem_req_o, instr_mem_addr_o); end
      if (i < 2) cyc();
    end
    gnt_en = 1;
    cyc();
    checks++; if (instr_mem_addr_o !== 32'h1000) begin errors++; $display("FAIL t3_gnt_cycle: addr %h exp 1000", instr_mem_addr_o); end
    cyc();
    checks++; if (instr_mem_addr_o !== 32'h1004) begin errors++; $display("FAIL t3_inc: addr %h exp 1004", instr_mem_addr_o); end
  endtask

  task automatic test_redirect();
    bit seen_req, seen_valid;
    set_ctl(1, 1, 0);
    do_reset();
    cyc();
    cyc();
    checks++; if (instr_mem_req_o !== 1'b0) begin errors++; $display("FAIL t4_two_out: req %b exp 0", instr_mem_req_o); end
    redir_en = 1; redir_pc = 32'h2002;
    cyc();
    checks++; if (instr_mem_req_o !== 1'b0) begin errors++; $display("FAIL t4_redir_req: got %b exp 0", instr_mem_req_o); end
    redir_en = 0; mem_on = 1;
    cyc();
    checks++; if (instr_mem_addr_o !== 32'h2000) begin errors++; $display("FAIL t4_addr: got %h exp 2000", instr_mem_addr_o); end
    seen_req = instr_mem_req_o;
    for (int i = 0; i < 8 && !seen_req; i++) begin
      cyc();
      seen_req = instr_mem_req_o;
    end
    checks++; if (!seen_req || instr_mem_addr_o !== 32'h2000) begin errors++; $display("FAIL t4_newreq: req %b addr %h exp 1 2000", seen_req, instr_mem_addr_o); end
    seen_valid = instr_valid_o;
    for (int i = 0; i < 8 && !seen_valid; i++) begin
      cyc();
      seen_valid = instr_valid_o;
    end
    checks++; if (!seen_valid || instr_pc_o !== 32'h2000 || instr_o !== (32'h2000 ^ K)) begin errors++; $display("FAIL t4_first: valid %b pc %h instr %h exp 1 2000 %h", seen_valid, instr_pc_o, instr_o, 32'h2000 ^ K); end
  endtask

  task automatic test_redirect_rvalid_pop();
    set_ctl(1, 0, 1);
    do_reset();
    cyc();
    cyc();
    mem_on = 0;
    cyc();
    cyc();
    checks++; if (instr_mem_req_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h1000) begin errors++; $display("FAIL t5_setup: req %b valid %b pc %h exp 0 1 1000", instr_mem_req_o, instr_valid_o, instr_pc_o); end
    mem_on = 1; rdy_en = 1; redir_en = 1; redir_pc = 32'h3000;
    cyc();
    checks++; if (instr_mem_rvalid_i !== 1'b1 || instr_mem_req_o !== 1'b0) begin errors++; $display("FAIL t5_redir_cycle: rvalid %b req %b exp 1 0", instr_mem_rvalid_i, instr_mem_req_o); end
    redir_en = 0;
    cyc();
    checks++; if (instr_valid_o !== 1'b0 || instr_mem_req_o !== 1'b1 || instr_mem_addr_o !== 32'h3000) begin errors++; $display("FAIL t5_flush: valid %b req %b addr %h exp 0 1 3000", instr_valid_o, instr_mem_req_o, instr_mem_addr_o); end
    cyc();
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL t5_dropped: valid %b pc %h exp 0", instr_valid_o, instr_pc_o); end
    cyc();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h3000 || instr_o !== (32'h3000 ^ K)) begin errors++; $display("FAIL t5_new: valid %b pc %h instr %h exp 1 3000 %h", instr_valid_o, instr_pc_o, instr_o, 32'h3000 ^ K); end
  endtask

  task automatic test_wrap();
    set_ctl(0, 1, 1);
    do_reset();
    redir_en = 1; redir_pc = 32'hFFFF_FFFC;
    cyc();
    redir_en = 0; gnt_en = 1;
    cyc();
    checks++; if (instr_mem_req_o !== 1'b1 || instr_mem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL t6_top: req %b addr %h exp 1 fffffffc", instr_mem_req_o, instr_mem_addr_o); end
    cyc();
    checks++; if (instr_mem_addr_o !== 32'h0) begin errors++; $display("FAIL t6_wrap_addr: got %h exp 0", instr_mem_addr_o); end
    cyc();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC || instr_o !== (32'hFFFF_FFFC ^ K)) begin errors++; $display("FAIL t6_pc0: valid %b pc %h instr %h exp 1 fffffffc", instr_valid_o, instr_pc_o, instr_o); end
    cyc();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== K) begin errors++; $display("FAIL t6_pc1: valid %b pc %h instr %h exp 1 0 %h", instr_valid_o, instr_pc_o, instr_o, K); end
  endtask

  task automatic test_stray_rvalid();
    bit seen_valid;
    set_ctl(0, 1, 0);
    force_rv = 1;
    do_reset();
    force_rv = 0;
    cyc();
    checks++; if (instr_valid_o !== 1'b0 || instr_mem_addr_o !== 32'h1000 || instr_mem_req_o !== 1'b1) begin errors++; $display("FAIL t7_ignored: valid %b addr %h req %b exp 0 1000 1", instr_valid_o, instr_mem_addr_o, instr_mem_req_o); end
    gnt_en = 1; mem_on = 1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6 && !seen_valid; i++) begin
      cyc();
      seen_valid = instr_valid_o;
    end
    checks++; if (!seen_valid || instr_pc_o !== 32'h1000 || instr_o !== (32'h1000 ^ K)) begin errors++; $display("FAIL t7_after: valid %b pc %h instr %h exp 1 1000 %h", seen_valid, instr_pc_o, instr_o, 32'h1000 ^ K); end
  endtask

  initial begin
    set_ctl(0, 0, 0);
    test_stream();
    test_fifo_full();
    test_gnt_stall();
    test_redirect();
    test_redirect_rvalid_pop();
    test_wrap();
    test_stray_rvalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
